dpcm_rle: RTL and testbench

//  Run-length encoder directly downstream of the DPCM stage. Consumes the

---
 rtl/dpcm_pkg.sv | 19 +
 rtl/dpcm_rle_stats.sv | 30 +++
 rtl/dpcm_rle.sv | 170 +++++++++++++++++
 tb/tb_dpcm_rle.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpcm_pkg.sv
// Shared types and constants for the DPCM compression chain.
package dpcm_pkg;

  localparam int DPCM_DW     = 32;
  localparam int RLE_MAX_RUN = 255;
  localparam int RLE_RW      = $clog2(RLE_MAX_RUN + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } rle_state_e;

  typedef struct packed {
    logic [DPCM_DW-1:0] value;
    logic [RLE_RW-1:0]  run;
  } rle_token_t;

endpackage

// File: rtl/dpcm_rle_stats.sv
// Activity counters for the run-length encoder; present only when RLE_STATS_EN is defined.
`ifdef RLE_STATS_EN
module rle_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        word_acc_i,
  input  logic        token_acc_i,
  output logic [31:0] stat_words_o,
  output logic [31:0] stat_tokens_o
);

  logic [31:0] words_q;
  logic [31:0] tokens_q;

  // Both counters wrap freely; they are free-running activity counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      words_q  <= '0;
      tokens_q <= '0;
    end else begin
      if (word_acc_i)  words_q  <= words_q + 32'd1;
      if (token_acc_i) tokens_q <= tokens_q + 32'd1;
    end
  end

  assign stat_words_o  = words_q;
  assign stat_tokens_o = tokens_q;

endmodule
`endif

// File: rtl/dpcm_rle.sv
// Run-length encoder after the DPCM stage: residual stream in, (value, run) tokens out.
// Optional activity counters are built in when RLE_STATS_EN is defined.
module dpcm_rle
  import dpcm_pkg::*;
#(
  parameter  int DW      = DPCM_DW,
  parameter  int MAX_RUN = RLE_MAX_RUN,
  localparam int RW      = $clog2(MAX_RUN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_value,
  output logic [RW-1:0] out_run,
  output logic          flush_done
`ifdef RLE_STATS_EN
  ,
  output logic [31:0]   stat_words,
  output logic [31:0]   stat_tokens
`endif
);

  rle_state_e    state_q, state_d;
  logic [DW-1:0] run_val_q, run_val_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_value_q, out_value_d;
  logic [RW-1:0] out_run_q, out_run_d;
  logic          flush_done_q, flush_done_d;
  logic          flush_pend_q, flush_pend_d;

  logic          accept, flush_acc, out_fire, extend, close_run;
  logic          tok_load;
  logic [DW-1:0] tok_value;
  logic [RW-1:0] tok_run;

  assign in_ready  = !out_valid_q && !flush_pend_q;
  assign accept    = in_valid && in_ready;
  assign flush_acc = flush && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign extend    = accept && (in_data == run_val_q) && (run_cnt_q < RW'(MAX_RUN));
  assign close_run = accept && !extend;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = flush_acc ? FLUSH : RUN;
      RUN:     if (flush_acc) state_d = FLUSH;
      FLUSH:   if (run_cnt_q == '0 && out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // run_cnt_q==0 in FLUSH means the final token has already been loaded.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    run_val_d    = run_val_q;
    run_cnt_d    = run_cnt_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;
    tok_load     = 1'b0;
    tok_value    = run_val_q;
    tok_run      = run_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          run_val_d = in_data;
          run_cnt_d = RW'(1);
          if (flush_acc) begin
            tok_load     = 1'b1;
            tok_value    = in_data;
            tok_run      = RW'(1);
            run_cnt_d    = '0;
            flush_pend_d = 1'b1;
          end
        end else if (flush_acc) begin
          flush_done_d = 1'b1;
        end
      end
      RUN: begin
        if (close_run) begin
          tok_load  = 1'b1;
          run_val_d = in_data;
          run_cnt_d = RW'(1);
        end else if (extend) begin
          run_cnt_d = run_cnt_q + RW'(1);
        end
        // With no token pending, the open run leaves on the same edge as the flush.
        if (flush_acc) begin
          flush_pend_d = 1'b1;
          if (!close_run) begin
            tok_load  = 1'b1;
            tok_run   = run_cnt_d;
            run_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        if (run_cnt_q != '0) begin
          if (!out_valid_q || out_ready) begin
            tok_load  = 1'b1;
            run_cnt_d = '0;
          end
        end else if (out_fire) begin
          flush_done_d = 1'b1;
          flush_pend_d = 1'b0;
        end
      end
      default: ;
    endcase

    out_valid_d = out_valid_q && !out_ready;
    out_value_d = out_value_q;
    out_run_d   = out_run_q;
    if (tok_load) begin
      out_valid_d = 1'b1;
      out_value_d = tok_value;
      out_run_d   = tok_run;
    end
  end

  // NOTE: datapath registers are reset as well so no stale token survives a reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_val_q    <= '0;
      run_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_value_q  <= '0;
      out_run_q    <= '0;
      flush_done_q <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      run_val_q    <= run_val_d;
      run_cnt_q    <= run_cnt_d;
      out_valid_q  <= out_valid_d;
      out_value_q  <= out_value_d;
      out_run_q    <= out_run_d;
      flush_done_q <= flush_done_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_value  = out_value_q;
  assign out_run    = out_run_q;
  assign flush_done = flush_done_q;

`ifdef RLE_STATS_EN
  rle_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .word_acc_i   (accept),
    .token_acc_i  (out_fire),
    .stat_words_o (stat_words),
    .stat_tokens_o(stat_tokens)
  );
`endif

endmodule

// File: tb/tb_dpcm_rle.sv
// Self-checking bench for dpcm_rle: directed scenarios plus randomized batches
// checked against a run-length model computed from the accepted word list.
module tb_dpcm_rle;
  import dpcm_pkg::*;

  localparam int BUDGET = 2000;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DPCM_DW-1:0] in_data = '0;
  logic               flush = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [DPCM_DW-1:0] out_value;
  logic [RLE_RW-1:0]  out_run;
  logic               flush_done;
`ifdef RLE_STATS_EN
  logic [31:0]        stat_words;
  logic [31:0]        stat_tokens;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DPCM_DW-1:0] words_q[$];
  rle_token_t         exp_q[$];
  rle_token_t         got_q[$];
  rle_token_t         last_got[$];
  int                 fd_cnt = 0;
  int                 n_flush = 0;
  bit                 had_run = 1'b0;
  bit                 rand_ready = 1'b0;
  bit                 stall_prev = 1'b0;
  logic [DPCM_DW-1:0] prev_value = '0;
  logic [RLE_RW-1:0]  prev_run = '0;
  int unsigned        total_words = 0;
  int unsigned        total_tokens = 0;

  dpcm_rle dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_run   (out_run),
    .flush_done(flush_done)
`ifdef RLE_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_tokens(stat_tokens)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic rle_token_t mk(input logic [DPCM_DW-1:0] v, input int r);
    rle_token_t t;
    t.value = v;
    t.run   = RLE_RW'(r);
    return t;
  endfunction

  // Model: group the words seen since the last flush into equal-value runs,
  // splitting any run longer than RLE_MAX_RUN into full-size pieces.
  function automatic void model_close();
    int i;
    int len;
    logic [DPCM_DW-1:0] v;
    had_run = (words_q.size() != 0);
    i = 0;
    while (i < words_q.size()) begin
      v   = words_q[i];
      len = 0;
      while (i < words_q.size() && words_q[i] == v) begin
        len++;
        i++;
      end
      while (len > RLE_MAX_RUN) begin
        exp_q.push_back(mk(v, RLE_MAX_RUN));
        len -= RLE_MAX_RUN;
      end
      exp_q.push_back(mk(v, len));
    end
    words_q.delete();
  endfunction

  task automatic observe();
    if (flush_done) fd_cnt++;
    if (out_valid) begin
      check("in_ready_low_while_token", in_ready, 1'b0);
      check("run_nonzero", out_run != '0, 1'b1);
    end
    if (stall_prev) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_value", out_value, prev_value);
      check("stall_run", out_run, prev_run);
    end
    if (in_valid && in_ready) begin
      words_q.push_back(in_data);
      total_words++;
    end
    if (flush && in_ready) model_close();
    if (out_valid && out_ready) begin
      got_q.push_back(mk(out_value, int'(out_run)));
      total_tokens++;
    end
    stall_prev = out_valid && !out_ready;
    prev_value = out_value;
    prev_run   = out_run;
  endtask

  // Called at a falling edge with inputs set; observes, then advances one clock.
  task automatic cycle();
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    if (rst) observe();
    @(negedge clk);
  endtask

  task automatic send(input logic [DPCM_DW-1:0] w);
    bit ok;
    bit acc;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      acc = in_ready;
      cycle();
      ok = acc;
    end
    in_valid = 1'b0;
    check("send_accepted", ok, 1'b1);
  endtask

  task automatic do_flush(input bit with_word, input logic [DPCM_DW-1:0] w);
    bit ok;
    bit acc;
    int fd0;
    ok  = 1'b0;
    fd0 = fd_cnt;
    n_flush++;
    flush    = 1'b1;
    in_valid = with_word;
    in_data  = w;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      acc = in_ready;
      cycle();
      ok = acc;
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_accepted", ok, 1'b1);
    if (ok && had_run) check("flush_token_latency", out_valid, 1'b1);
    for (int i = 0; i < BUDGET && fd_cnt == fd0; i++) cycle();
    check("flush_done_seen", fd_cnt != fd0, 1'b1);
    cycle();
    cycle();
    check("flush_done_once", fd_cnt - fd0, 1);
    check("tok_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("tok_value", got_q[i].value, exp_q[i].value);
      check("tok_run", got_q[i].run, exp_q[i].run);
    end
    last_got = got_q;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_tokens(input string tag, input rle_token_t e[$]);
    check({tag, "_count"}, last_got.size(), e.size());
    for (int i = 0; i < e.size() && i < last_got.size(); i++) begin
      check({tag, "_value"}, last_got[i].value, e[i].value);
      check({tag, "_run"}, last_got[i].run, e[i].run);
    end
  endtask

  initial begin
    rle_token_t         e[$];
    logic [DPCM_DW-1:0] v;
    int                 n;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_value", out_value, '0);
    check("reset_out_run", out_run, '0);
    check("reset_flush_done", flush_done, 1'b0);
    @(negedge clk);

    // T2: basic runs; the closing word makes the token visible one cycle later.
    send(32'd5); send(32'd5); send(32'd5);
    send(32'd7);
    check("t2_close_latency", out_valid, 1'b1);
    check("t2_first_value", out_value, 32'd5);
    check("t2_first_run", out_run, 8'd3);
    do_flush(1'b0, '0);
    e.delete(); e.push_back(mk(32'd5, 3)); e.push_back(mk(32'd7, 1));
    expect_tokens("t2", e);
`ifdef RLE_STATS_EN
    check("t6_stat_words", stat_words, 32'd4);
    check("t6_stat_tokens", stat_tokens, 32'd2);
`endif

    // T3: saturation at the maximum run length.
    repeat (256) send(32'd9);
    do_flush(1'b0, '0);
    e.delete(); e.push_back(mk(32'd9, 255)); e.push_back(mk(32'd9, 1));
    expect_tokens("t3", e);

    // T4: downstream stall holds the token and blocks input.
    out_ready = 1'b0;
    send(32'd1);
    send(32'd2);
    in_valid = 1'b1;
    in_data  = 32'd1;
    repeat (4) begin
      check("t4_in_ready_stalled", in_ready, 1'b0);
      cycle();
    end
    out_ready = 1'b1;
    send(32'd1);
    send(32'd2);
    do_flush(1'b0, '0);
    e.delete();
    e.push_back(mk(32'd1, 1)); e.push_back(mk(32'd2, 1));
    e.push_back(mk(32'd1, 1)); e.push_back(mk(32'd2, 1));
    expect_tokens("t4", e);

    // T5: flush carrying a matching word, then a flush with nothing open.
    send(32'd3); send(32'd3);
    do_flush(1'b1, 32'd3);
    e.delete(); e.push_back(mk(32'd3, 3));
    expect_tokens("t5_word", e);
    do_flush(1'b0, '0);
    check("t5_idle_no_token", last_got.size(), 0);

    // T1: reset mid-run with a stalled token outstanding.
    out_ready = 1'b0;
    send(32'd4); send(32'd4); send(32'd5);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t1_out_valid", out_valid, 1'b0);
    check("t1_in_ready", in_ready, 1'b1);
    check("t1_out_run", out_run, '0);
    check("t1_flush_done", flush_done, 1'b0);
    words_q.delete(); got_q.delete(); exp_q.delete();
    stall_prev   = 1'b0;
    total_words  = 0;
    total_tokens = 0;
    out_ready    = 1'b1;
    @(negedge clk);
    do_flush(1'b0, '0);
    check("t1_no_stale_token", last_got.size(), 0);

    // Randomized batches with random backpressure.
    rand_ready = 1'b1;
    v = '0;
    for (int b = 0; b < 30; b++) begin
      if (b % 10 == 9) begin
        v = $urandom;
        n = $urandom_range(250, 520);
        repeat (n) send(v);
      end else begin
        n = $urandom_range(1, 40);
        repeat (n) begin
          if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 4))
              0:       v = 32'd0;
              1:       v = 32'd1;
              2:       v = 32'h8000_0001;
              3:       v = 32'hFFFF_FFFF;
              default: v = $urandom;
            endcase
          end
          send(v);
        end
      end
      do_flush(1'($urandom_range(0, 1)), v);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    check("flush_done_total", fd_cnt, n_flush);
`ifdef RLE_STATS_EN
    check("stat_words_total", stat_words, total_words);
    check("stat_tokens_total", stat_tokens, total_tokens);
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
